// File: rtl/chacha20_xor_stream_if.sv
// Plaintext-in / ciphertext-out word stream bundle for chacha20_xor_stream.
// The slave modport is the cipher block; the master modport is the producer/consumer side.
interface chacha20_xor_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/chacha20_xor_stream.sv
// XORs a 32-bit word stream with ChaCha20 keystream blocks fetched from an external generator.
// Define CHACHA_XOR_PREFETCH_EN to add a second block buffer that is fetched one block ahead.
module chacha20_xor_stream (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [31:0]          init_counter,
    output logic                 ks_start,
    output logic [31:0]          ks_counter,
    input  logic [511:0]         ks_block,
    input  logic                 ks_done,
    chacha20_xor_stream_if.slave strm,
    output logic                 ctr_wrap
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, HALT} state_t;

    state_t       state, state_n;
    logic [31:0]  counter, counter_n, init_ctr, init_ctr_n;
    logic [3:0]   idx, idx_n;
    logic [511:0] kbuf, kbuf_n;
    logic         init_pend, init_pend_n, wrap_n;
    logic         xfer, done_ok, req_n, pf_go;
    logic [31:0]  ks_word;
`ifdef CHACHA_XOR_PREFETCH_EN
    logic [511:0] pbuf, pbuf_n;
    logic         pf_pend, pf_pend_n, pf_full, pf_full_n, pf_drop, pf_drop_n;
    logic         pf_avail, pf_stale;

    // A prefetch abandoned in flight leaves one ks_done that must not be mistaken for a new block.
    assign done_ok  = ks_done && !pf_drop;
    assign pf_stale = pf_pend && !done_ok;
`else
    assign done_ok  = ks_done;
`endif

    assign xfer    = strm.in_valid && strm.in_ready;
    assign ks_word = kbuf[9'd511 - {idx, 5'd0} -: 32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        counter_n   = counter;
        idx_n       = idx;
        kbuf_n      = kbuf;
        init_pend_n = init_pend;
        init_ctr_n  = init_ctr;
        wrap_n      = ctr_wrap;
        pf_go       = 1'b0;
`ifdef CHACHA_XOR_PREFETCH_EN
        pbuf_n    = pbuf;
        pf_pend_n = pf_pend;
        pf_full_n = pf_full;
        pf_drop_n = pf_drop && !ks_done;
        pf_avail  = pf_full || (done_ok && pf_pend);
        if (state == STREAM && done_ok && pf_pend) begin
            pbuf_n    = ks_block;
            pf_full_n = 1'b1;
            pf_pend_n = 1'b0;
        end
`endif
        unique case (state)
            REQ: state_n = WAIT;
            WAIT: begin
                if (done_ok) begin
`ifdef CHACHA_XOR_PREFETCH_EN
                    pf_pend_n = 1'b0;
`endif
                    if (init || init_pend) begin
                        counter_n   = init ? init_counter : init_ctr;
                        init_pend_n = 1'b0;
                        state_n     = REQ;
                    end else begin
                        kbuf_n  = ks_block;
                        idx_n   = '0;
                        state_n = STREAM;
`ifdef CHACHA_XOR_PREFETCH_EN
                        pf_go   = (counter != '1);
`endif
                    end
                end else if (init) begin
                    init_pend_n = 1'b1;
                    init_ctr_n  = init_counter;
                end
            end
            STREAM: begin
                if (xfer) begin
                    idx_n = idx + 4'd1;
                    if (strm.in_last || idx == 4'd15) begin
                        if (counter == '1) begin
                            wrap_n  = 1'b1;
                            state_n = HALT;
                        end else begin
                            counter_n = counter + 32'd1;
                            if (strm.in_last) begin
                                state_n = IDLE;
`ifdef CHACHA_XOR_PREFETCH_EN
                                pf_full_n = 1'b0;
                                pf_pend_n = 1'b0;
                                pf_drop_n = pf_drop_n || pf_stale;
                            end else if (pf_avail) begin
                                // Swap straight from the incoming block if it lands on the word-15 cycle.
                                kbuf_n    = pf_full ? pbuf : ks_block;
                                idx_n     = '0;
                                pf_full_n = 1'b0;
                                pf_pend_n = 1'b0;
                                pf_go     = (counter != 32'hFFFF_FFFE);
                            end else begin
                                state_n = pf_pend ? WAIT : REQ;
`else
                            end else begin
                                state_n = REQ;
`endif
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
        if (init && state != WAIT) begin
            state_n   = REQ;
            counter_n = init_counter;
            wrap_n    = 1'b0;
            pf_go     = 1'b0;
`ifdef CHACHA_XOR_PREFETCH_EN
            pf_full_n = 1'b0;
            pf_pend_n = 1'b0;
            pf_drop_n = pf_drop_n || pf_stale;
`endif
        end
`ifdef CHACHA_XOR_PREFETCH_EN
        if (pf_go) pf_pend_n = 1'b1;
`endif
    end

    always_comb begin
        strm.in_ready = (state == STREAM) && (!strm.out_valid || strm.out_ready);
        req_n         = (state_n == REQ) || pf_go;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter       <= '0;
            idx           <= '0;
            kbuf          <= '0;
            init_pend     <= 1'b0;
            init_ctr      <= '0;
            ctr_wrap      <= 1'b0;
            ks_start      <= 1'b0;
            ks_counter    <= '0;
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
            strm.out_last  <= 1'b0;
`ifdef CHACHA_XOR_PREFETCH_EN
            pbuf    <= '0;
            pf_pend <= 1'b0;
            pf_full <= 1'b0;
            pf_drop <= 1'b0;
`endif
        end else begin
            counter   <= counter_n;
            idx       <= idx_n;
            kbuf      <= kbuf_n;
            init_pend <= init_pend_n;
            init_ctr  <= init_ctr_n;
            ctr_wrap  <= wrap_n;
            ks_start  <= req_n;
            if (req_n) ks_counter <= (state_n == REQ) ? counter_n : counter_n + 32'd1;
            if (xfer) begin
                strm.out_data  <= strm.in_data ^ ks_word;
                strm.out_last  <= strm.in_last;
                strm.out_valid <= 1'b1;
            end else if (strm.out_ready) begin
                strm.out_valid <= 1'b0;
            end
`ifdef CHACHA_XOR_PREFETCH_EN
            pbuf    <= pbuf_n;
            pf_pend <= pf_pend_n;
            pf_full <= pf_full_n;
            pf_drop <= pf_drop_n;
`endif
        end
    end
endmodule

// File: tb/tb_chacha20_xor_stream.sv
// Directed bench for chacha20_xor_stream with a stub keystream generator
// (ks_done 4 cycles after ks_start, word i = requested counter + i).
module tb_chacha20_xor_stream;
    logic         clk = 1'b0;
    logic         reset, init, force_done, ctr_wrap, ks_start, ks_done;
    logic [31:0]  init_counter, ks_counter;
    logic [511:0] ks_block;
    logic [3:0]   dv;
    logic [31:0]  dc0, dc1, dc2, dc3;
    logic [31:0]  req_log [$];
    int           tests = 0;
    int           fails = 0;

    typedef struct {
        logic [31:0] din;
        logic        last;
        logic [31:0] dout;
    } vec_t;
    vec_t tv [19];

    chacha20_xor_stream_if strm ();

    chacha20_xor_stream dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .init_counter (init_counter),
        .ks_start     (ks_start),
        .ks_counter   (ks_counter),
        .ks_block     (ks_block),
        .ks_done      (ks_done),
        .strm         (strm),
        .ctr_wrap     (ctr_wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv  <= '0;
            dc0 <= '0;
            dc1 <= '0;
            dc2 <= '0;
            dc3 <= '0;
        end else begin
            dv  <= {dv[2:0], ks_start};
            dc0 <= ks_counter;
            dc1 <= dc0;
            dc2 <= dc1;
            dc3 <= dc2;
            if (ks_start) req_log.push_back(ks_counter);
        end
    end

    assign ks_done = dv[3] || force_done;

    always_comb begin
        ks_block = '0;
        for (int i = 0; i < 16; i++) ks_block[511-32*i -: 32] = dc3 + 32'(i);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic requested(input logic [31:0] c);
        foreach (req_log[i]) if (req_log[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic pulse_init(input logic [31:0] c);
        init = 1'b1;
        init_counter = c;
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic send(input string nm, input logic [31:0] d, input logic l,
                        input logic [31:0] e, output int waits);
        waits = 0;
        strm.in_valid = 1'b1;
        strm.in_data  = d;
        strm.in_last  = l;
        while (!strm.in_ready && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!strm.in_ready) begin
            strm.in_valid = 1'b0;
            chk({nm, " in_ready timeout"}, 32'(strm.in_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
            strm.in_valid = 1'b0;
            strm.in_last  = 1'b0;
            chk(nm, strm.out_data, e);
            chk({nm, " last"}, 32'(strm.out_last), 32'(l));
            chk({nm, " valid"}, 32'(strm.out_valid), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        int w;
`ifdef CHACHA_XOR_PREFETCH_EN
        int stalls;
`endif
        for (int i = 0; i < 16; i++) tv[i] = '{din: 32'h0, last: 1'b0, dout: 32'(i + 1)};
        tv[16] = '{din: 32'hFFFF_0000, last: 1'b0, dout: 32'hFFFF_0002};
        tv[17] = '{din: 32'h0000_0010, last: 1'b0, dout: 32'h0000_0013};
        tv[18] = '{din: 32'h1234_5678, last: 1'b1, dout: 32'h1234_567C};

        reset = 1'b0; init = 1'b0; init_counter = '0; force_done = 1'b0;
        strm.in_valid = 1'b0; strm.in_data = '0; strm.in_last = 1'b0; strm.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(strm.in_ready), 32'd0);
        chk("rst out_valid", 32'(strm.out_valid), 32'd0);
        chk("rst out_data", strm.out_data, 32'd0);
        chk("rst out_last", 32'(strm.out_last), 32'd0);
        chk("rst ks_start", 32'(ks_start), 32'd0);
        chk("rst ks_counter", ks_counter, 32'd0);
        chk("rst ctr_wrap", 32'(ctr_wrap), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Stray ks_done in IDLE must not start streaming
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        @(posedge clk); #1;
        chk("idle ks_done in_ready", 32'(strm.in_ready), 32'd0);
        chk("idle ks_done no request", 32'(req_log.size()), 32'd0);

        // Block 1 then 3 words of block 2 ending in in_last
        pulse_init(32'd1);
        chk("init ks_start", 32'(ks_start), 32'd1);
        chk("init ks_counter", ks_counter, 32'd1);
        @(posedge clk); #1;
        chk("ks_start one cycle", 32'(ks_start), 32'd0);
        for (int i = 0; i < 19; i++) send($sformatf("tv%0d", i), tv[i].din, tv[i].last, tv[i].dout, w);
        chk("block2 requested", 32'(requested(32'd2)), 32'd1);
        @(posedge clk); #1;
        chk("counter after last", dut.counter, 32'd3);
        strm.in_valid = 1'b1;
        w = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (strm.in_ready) w++;
        end
        strm.in_valid = 1'b0;
        chk("idle in_ready cycles", 32'(w), 32'd0);

        // Back-pressure for 5 cycles mid-block
        req_log.delete();
        pulse_init(32'd10);
        send("bp w0", 32'h0, 1'b0, 32'd10, w);
        send("bp w1", 32'h0, 1'b0, 32'd11, w);
        send("bp w2", 32'h0, 1'b0, 32'd12, w);
        strm.out_ready = 1'b0;
        strm.in_valid  = 1'b1;
        strm.in_data   = 32'h0000_0F00;
        strm.in_last   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold data c%0d", c), strm.out_data, 32'd12);
            chk($sformatf("bp hold in_ready c%0d", c), 32'(strm.in_ready), 32'd0);
            chk($sformatf("bp hold valid c%0d", c), 32'(strm.out_valid), 32'd1);
        end
        strm.out_ready = 1'b1;
        @(posedge clk); #1;
        strm.in_valid = 1'b0;
        chk("bp w3", strm.out_data, 32'h0000_0F0D);
        send("bp w4", 32'h0, 1'b1, 32'd14, w);
        chk("bp single request", 32'(req_log.size() >= 1 && req_log[0] == 32'd10), 32'd1);

        // Counter exhaustion at 0xFFFFFFFF
        pulse_init(32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++)
            send($sformatf("wrap w%0d", i), 32'h0, 1'b0, (i == 0) ? 32'hFFFF_FFFF : 32'(i - 1), w);
        chk("wrap flag", 32'(ctr_wrap), 32'd1);
        chk("wrap counter held", dut.counter, 32'hFFFF_FFFF);
        strm.in_valid = 1'b1;
        w = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (strm.in_ready) w++;
        end
        strm.in_valid = 1'b0;
        chk("halt in_ready cycles", 32'(w), 32'd0);
        chk("wrap sticky", 32'(ctr_wrap), 32'd1);
        pulse_init(32'd0);
        chk("wrap cleared", 32'(ctr_wrap), 32'd0);
        send("resume w0", 32'h55, 1'b0, 32'h55, w);
        send("resume w1", 32'h55, 1'b1, 32'h54, w);

        // init during WAIT: stale block discarded, latched counter applied
        req_log.delete();
        pulse_init(32'd20);
        chk("wait req ctr", ks_counter, 32'd20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_init(32'd7);
        send("latched w0", 32'h0, 1'b0, 32'd7, w);
        send("latched w1", 32'h0, 1'b1, 32'd8, w);
        chk("latched requested", 32'(requested(32'd7)), 32'd1);

        // 32 words back-to-back across a block boundary
        pulse_init(32'd100);
`ifdef CHACHA_XOR_PREFETCH_EN
        stalls = 0;
`endif
        for (int i = 0; i < 32; i++) begin
            send($sformatf("b2b w%0d", i), 32'h0, (i == 31),
                 (i < 16) ? 32'(100 + i) : 32'(101 + i - 16), w);
`ifdef CHACHA_XOR_PREFETCH_EN
            if (i > 0) stalls += w;
`endif
        end
`ifdef CHACHA_XOR_PREFETCH_EN
        chk("prefetch no bubble", 32'(stalls), 32'd0);
`endif
        chk("b2b counter", dut.counter, 32'd102);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
